// File: rtl/mc_pkg.sv
// mc_pkg: shared state, ALU control and data-processing opcode encodings
package mc_pkg;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH
  } state_t;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_EOR = 3'b100;
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_TEQ = 4'b1001;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_CMN = 4'b1011;
  localparam logic [3:0] OP_ORR = 4'b1100;
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: data-processing ALU control, flag write enables and legality
module alu_decoder
  import mc_pkg::*;
#(
  parameter bit EXT_ALU = 1'b1
) (
  input  logic [1:0] op_i,
  input  logic [5:0] funct_i,
  input  logic       dp_i,
  input  logic       flag_en_i,
  output logic [2:0] alu_control_o,
  output logic [1:0] flag_w_o,
  output logic       no_write_o,
  output logic       illegal_o
);
  logic [2:0] alu;
  logic       legal, s_bit;
  // Map Funct[4:1] to an ALU operation; extended ops only exist with EXT_ALU
  always_comb begin
    alu = ALU_ADD;
    legal = 1'b1;
    case (funct_i[4:1])
      OP_ADD: alu = ALU_ADD;
      OP_SUB, OP_CMP: alu = ALU_SUB;
      OP_AND, OP_TST: alu = ALU_AND;
      OP_ORR: alu = ALU_ORR;
      OP_EOR, OP_TEQ: begin alu = EXT_ALU ? ALU_EOR : ALU_ADD; legal = EXT_ALU; end
      OP_CMN: legal = EXT_ALU;
      default: legal = 1'b0;
    endcase
  end
  assign no_write_o = op_i == 2'b00 && funct_i[4:3] == 2'b10;
  assign illegal_o = dp_i && !legal;
  assign alu_control_o = dp_i && legal ? alu : ALU_ADD;
  assign s_bit = funct_i[0] | no_write_o;
  assign flag_w_o = flag_en_i && legal ? {s_bit, s_bit && alu_control_o[2:1] == 2'b00} : 2'b00;
endmodule

// File: rtl/mc_decoder.sv
// mc_decoder: multicycle Moore control FSM for a small ARM-like datapath
module mc_decoder
  import mc_pkg::*;
#(
  parameter bit EXT_ALU = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic       PCS,
  output logic       RegW,
  output logic       MemW,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic       NoWrite,
  output logic       Illegal,
  output logic       InstrDone,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] FlagW,
  output logic [2:0] ALUControl
);
  state_t state_q, state_d, st;
  logic   no_write, dp_illegal, branch;
  // While reset is held the outputs already show FETCH, with fetch side effects masked
  assign st = reset ? FETCH : state_q;
  alu_decoder #(.EXT_ALU(EXT_ALU)) u_alu (
    .op_i         (Op),
    .funct_i      (Funct),
    .dp_i         (st inside {EXECUTER, EXECUTEI, ALUWB}),
    .flag_en_i    (st inside {EXECUTER, EXECUTEI}),
    .alu_control_o(ALUControl),
    .flag_w_o     (FlagW),
    .no_write_o   (no_write),
    .illegal_o    (dp_illegal)
  );
  // State register
  always_ff @(posedge clk) state_q <= reset ? FETCH : state_d;
  // Next-state selection from the instruction class
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH: state_d = DECODE;
      DECODE: state_d = Op == 2'b00 ? (Funct[5] ? EXECUTEI : EXECUTER) :
                        Op == 2'b01 ? MEMADR : Op == 2'b10 ? BRANCH : FETCH;
      MEMADR: state_d = Funct[0] ? MEMREAD : MEMWRITE;
      MEMREAD: state_d = MEMWB;
      EXECUTER, EXECUTEI: state_d = ALUWB;
      default: state_d = FETCH;
    endcase
  end
  // Per-state datapath controls
  always_comb begin
    IRWrite = 1'b0;
    NextPC = 1'b0;
    AdrSrc = 1'b0;
    ALUSrcA = 1'b0;
    ALUSrcB = 2'b00;
    ResultSrc = 2'b00;
    MemW = 1'b0;
    RegW = 1'b0;
    Illegal = dp_illegal;
    InstrDone = 1'b0;
    branch = 1'b0;
    case (st)
      FETCH: begin
        IRWrite = ~reset;
        NextPC = ~reset;
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ResultSrc = 2'b10;
      end
      DECODE: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ResultSrc = 2'b10;
        Illegal = Op == 2'b11;
        InstrDone = Op == 2'b11;
      end
      MEMADR: ALUSrcB = 2'b01;
      MEMREAD: AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        RegW = 1'b1;
        InstrDone = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        MemW = 1'b1;
        InstrDone = 1'b1;
      end
      EXECUTEI: ALUSrcB = 2'b01;
      ALUWB: begin
        RegW = ~no_write & ~dp_illegal;
        InstrDone = 1'b1;
      end
      BRANCH: begin
        ALUSrcB = 2'b01;
        ResultSrc = 2'b10;
        branch = 1'b1;
        InstrDone = 1'b1;
      end
      default: ;
    endcase
  end
  assign NoWrite = no_write & ~reset;
  assign PCS = (Rd == 4'hF && RegW) || branch;
  assign ImmSrc = Op;
  assign RegSrc = {Op == 2'b01, Op == 2'b10};
endmodule

// File: doc/mc_decoder.md
MC_DECODER -- requirements
Module: mc_decoder

Interface
REQ-001 SHALL have parameter EXT_ALU, default 1, meaning EOR/TEQ/CMN are decoded; when 0 they are illegal.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports Op  input  2; Funct  input  6; Rd  input  4; all from the instruction register and stable from DECODE until the next FETCH.
REQ-005 SHALL have outputs PCS, RegW, MemW, IRWrite, NextPC, AdrSrc, ALUSrcA, NoWrite, Illegal, InstrDone, each 1 bit.
REQ-006 SHALL have outputs ResultSrc 2, ALUSrcB 2, ImmSrc 2, RegSrc 2, FlagW 2, ALUControl 3.

Function
REQ-007 SHALL be a multicycle Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH.
REQ-008 SHALL transition as follows:
- FETCH->DECODE.
- DECODE: Op=00 with Funct[5]=0 ->EXECUTER; Op=00 with Funct[5]=1 ->EXECUTEI; Op=01->MEMADR; Op=10->BRANCH; Op=11->FETCH with Illegal=1.
- MEMADR: Funct[0]=1 ->MEMREAD, else ->MEMWRITE.
- MEMREAD->MEMWB.
- EXECUTER/EXECUTEI->ALUWB.
- MEMWB, MEMWRITE, ALUWB, BRANCH->FETCH.
REQ-009 SHALL drive the following per state; any unlisted output is 0.
- FETCH: IRWrite=1, NextPC=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
- MEMADR: ALUSrcB=01.
- MEMREAD: AdrSrc=1.
- MEMWB: ResultSrc=01, RegW=1.
- MEMWRITE: AdrSrc=1, MemW=1.
- EXECUTER: ALUSrcB=00.
- EXECUTEI: ALUSrcB=01.
- ALUWB: RegW = not NoWrite and not Illegal.
- BRANCH: ALUSrcB=01, ResultSrc=10, internal Branch=1.
REQ-010 SHALL drive ImmSrc=Op, RegSrc[0]=(Op==10) and RegSrc[1]=(Op==01) combinationally in every state.
REQ-011 SHALL, in EXECUTER/EXECUTEI/ALUWB, map Funct[4:1] to ALUControl as follows: 0100 ADD 000; 0010 SUB 001; 0000 AND 010; 1100 ORR 011; 1010 CMP 001; 1000 TST 010. When EXT_ALU=1, it SHALL also map 0001 EOR 100; 1011 CMN 000; 1001 TEQ 100.
REQ-012 SHALL drive ALUControl=000 in all other states; MEMADR and BRANCH therefore add.
REQ-013 SHALL treat an unlisted Funct[4:1] in a data-processing instruction as follows: ALUControl=000, FlagW=00, RegW=0 in ALUWB, Illegal=1 in EXECUTER/EXECUTEI/ALUWB.
REQ-014 SHALL drive NoWrite=1 only when Op=00 and Funct[4:3]=10, i.e. compare/test.
REQ-015 SHALL assert FlagW only in EXECUTER/EXECUTEI, and FlagW SHALL be 00 elsewhere:
- FlagW[1] = Funct[0] OR NoWrite.
- FlagW[0] = FlagW[1] AND (ALUControl is 000 or 001).
REQ-016 SHALL compute PCS = ((Rd==1111) AND RegW) OR Branch combinationally.
REQ-017 SHALL pulse InstrDone for one cycle in MEMWB, MEMWRITE, ALUWB, BRANCH, and in DECODE when Op=11.
REQ-018 SHALL give latencies counted from entering FETCH, ending when FETCH is re-entered: LDR 5, STR 4, data-processing 4, B 3, illegal 2 cycles.
REQ-019 SHALL keep all outputs free of X for every input value.

Reset
REQ-020 SHALL, with reset high at a clk edge, load FETCH regardless of current state, including mid-instruction.
REQ-021 SHALL, while reset is high, drive the FETCH output values except IRWrite=0 and NextPC=0.
REQ-022 SHALL, while reset is high, hold MemW=0, RegW=0, FlagW=00, InstrDone=0 and Illegal=0.
REQ-023 SHALL, on the first cycle after reset deasserts, be in FETCH with IRWrite=1.

Structure
REQ-024 SHALL place the state enum, the ALUControl encodings, and the Funct[4:1] opcode constants in a shared package mc_pkg.
REQ-025 SHALL use one sub-module, alu_decoder, for the combinational ALUControl/FlagW/NoWrite/Illegal logic of REQ-011 to REQ-015; the FSM stays in mc_decoder.

Verification
REQ-026 SHALL cover ADD with S=1 (Op=00, Funct=101001, Rd=0011): states FETCH, DECODE, EXECUTEI, ALUWB; ALUControl=000; FlagW=11 in EXECUTEI only; RegW=1 in ALUWB; PCS=0.
REQ-027 SHALL cover LDR (Op=01, Funct=011001, Rd=1111): 5-cycle path through MEMREAD/MEMWB; PCS=1 in MEMWB; InstrDone once.
REQ-028 SHALL cover STR (Op=01, Funct=011000): MemW=1 only in MEMWRITE with AdrSrc=1; RegW=0 throughout.
REQ-029 SHALL cover CMP (Op=00, Funct=010101): NoWrite=1, FlagW=11, ALUControl=001; RegW=0 in ALUWB.
REQ-030 SHALL cover TEQ (Funct[4:1]=1001) with EXT_ALU=0: Illegal=1, FlagW=00, RegW=0; with EXT_ALU=1: ALUControl=100, FlagW=10.
REQ-031 SHALL cover reset asserted in MEMREAD: next state FETCH; no MemW/RegW pulse; B (Op=10) afterwards completes in 3 cycles with PCS=1 in BRANCH.
